// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of an asynchronous MFA/MFC memory handshake.
// Round-robin on ties, per-transfer timeout, registered memory-side outputs.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IF_REQ,
  input  logic [7:0]  IF_ADDR,
  output logic        IF_ACK,
  output logic [31:0] IF_DATA,
  input  logic        DA_REQ,
  input  logic        DA_RW,
  input  logic        DA_WB,
  input  logic [7:0]  DA_ADDR,
  input  logic [31:0] DA_WDATA,
  output logic        DA_ACK,
  output logic [31:0] DA_RDATA,
  output logic        ERR,
  input  logic        MFC,
  input  logic [31:0] MEMDAT_IN,
  output logic [7:0]  MEMADD,
  output logic        MFA,
  output logic        READ_WRITE,
  output logic        WORD_BYTE,
  output logic [31:0] MEMDAT_OUT
);

  typedef enum logic [1:0] {IDLE, WAIT_MFC, RELEASE, DONE} state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          mfc_meta, mfc_s;
  logic          last_da;
  logic          gnt_da;
  logic [31:0]   rd_hold;
  logic          grant, grant_da, abort, cnt_hit;

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    grant_da = 1'b0;
    abort    = 1'b0;
    cnt_hit  = (cnt == CW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (IF_REQ || DA_REQ) begin
          grant    = 1'b1;
          // data wins alone, or on a tie when fetch was served last
          grant_da = DA_REQ && (!IF_REQ || !last_da);
          state_n  = WAIT_MFC;
        end
      end
      WAIT_MFC: begin
        if (mfc_s) begin
          state_n = RELEASE;
        end else if (cnt_hit) begin
          state_n = DONE;
          abort   = 1'b1;
        end
      end
      RELEASE: begin
        if (!mfc_s) begin
          state_n = DONE;
        end else if (cnt_hit) begin
          state_n = DONE;
          abort   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mfc_meta   <= 1'b0;
      mfc_s      <= 1'b0;
      MFA        <= 1'b0;
      IF_ACK     <= 1'b0;
      DA_ACK     <= 1'b0;
      ERR        <= 1'b0;
      MEMADD     <= '0;
      MEMDAT_OUT <= '0;
      READ_WRITE <= 1'b1;
      WORD_BYTE  <= 1'b1;
      IF_DATA    <= '0;
      DA_RDATA   <= '0;
      rd_hold    <= '0;
      cnt        <= '0;
      last_da    <= 1'b0;
      gnt_da     <= 1'b0;
    end else begin
      mfc_meta <= MFC;
      mfc_s    <= mfc_meta;
      MFA      <= (state_n == WAIT_MFC);
      IF_ACK   <= (state_n == DONE) && !gnt_da;
      DA_ACK   <= (state_n == DONE) && gnt_da;
      ERR      <= abort;

      if (grant) begin
        gnt_da  <= grant_da;
        last_da <= grant_da;
        cnt     <= '0;
        if (grant_da) begin
          MEMADD     <= DA_ADDR;
          READ_WRITE <= DA_RW;
          WORD_BYTE  <= DA_WB;
          MEMDAT_OUT <= DA_WDATA;
        end else begin
          MEMADD     <= IF_ADDR;
          READ_WRITE <= 1'b1;
          WORD_BYTE  <= 1'b1;
        end
      end else if (state == WAIT_MFC || state == RELEASE) begin
        cnt <= cnt + 1'b1;
      end

      // read data is staged and only committed on a clean completion,
      // so a timeout in RELEASE leaves the visible data registers untouched
      if (state == WAIT_MFC && mfc_s && READ_WRITE)
        rd_hold <= WORD_BYTE ? MEMDAT_IN : {24'b0, MEMDAT_IN[7:0]};

      if (state == RELEASE && !mfc_s && READ_WRITE) begin
        if (gnt_da) DA_RDATA <= rd_hold;
        else        IF_DATA  <= rd_hold;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple MFA/MFC memory responder.
module tb_mem_arbiter;

  localparam int unsigned TO = 16;

  logic        Clk, Reset;
  logic        IF_REQ, DA_REQ, DA_RW, DA_WB, MFC;
  logic [7:0]  IF_ADDR, DA_ADDR, MEMADD;
  logic [31:0] DA_WDATA, MEMDAT_IN, IF_DATA, DA_RDATA, MEMDAT_OUT;
  logic        IF_ACK, DA_ACK, ERR, MFA, READ_WRITE, WORD_BYTE;

  int checks = 0;
  int fails  = 0;
  bit mem_en = 0;
  int mem_delay = 5;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_DATA(IF_DATA),
    .DA_REQ(DA_REQ), .DA_RW(DA_RW), .DA_WB(DA_WB), .DA_ADDR(DA_ADDR),
    .DA_WDATA(DA_WDATA), .DA_ACK(DA_ACK), .DA_RDATA(DA_RDATA), .ERR(ERR),
    .MFC(MFC), .MEMDAT_IN(MEMDAT_IN), .MEMADD(MEMADD), .MFA(MFA),
    .READ_WRITE(READ_WRITE), .WORD_BYTE(WORD_BYTE), .MEMDAT_OUT(MEMDAT_OUT)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // memory model: raise MFC mem_delay cycles after MFA, drop it once MFA falls
  initial begin
    MFC = 0;
    forever begin
      @(negedge Clk);
      if (mem_en && MFA && !MFC) begin
        repeat (mem_delay) @(negedge Clk);
        MFC = 1;
        for (int i = 0; i < 200 && MFA; i++) @(negedge Clk);
        MFC = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // waits for the port's ACK, drops its request, and reports what it saw
  task automatic xfer_wait(input bit is_da, input int budget, output bit got,
                           output int cyc, output bit err_at, output bit mfa_at,
                           output bit pulse_ok, output bit stable);
    bit          seen;
    logic [42:0] snap;
    got = 0; cyc = 0; err_at = 0; mfa_at = 0; pulse_ok = 0; stable = 1;
    seen = MFA;
    snap = {MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT};
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clk);
      if (seen) begin
        cyc++;
        if ({MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT} !== snap) stable = 0;
      end else if (MFA) begin
        seen = 1;
        snap = {MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT};
      end
      if (is_da ? DA_ACK : IF_ACK) begin
        got = 1; err_at = ERR; mfa_at = MFA;
        if (is_da) DA_REQ = 0; else IF_REQ = 0;
      end
    end
    if (got) begin
      @(negedge Clk);
      pulse_ok = !IF_ACK && !DA_ACK && !ERR;
    end
  endtask

  task automatic test_reset();
    Reset = 0; IF_REQ = 0; DA_REQ = 0; DA_RW = 1; DA_WB = 1;
    IF_ADDR = '0; DA_ADDR = '0; DA_WDATA = '0; MEMDAT_IN = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({MFA, IF_ACK, DA_ACK, ERR, READ_WRITE, WORD_BYTE} !== 6'b000011) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000011",
               {MFA, IF_ACK, DA_ACK, ERR, READ_WRITE, WORD_BYTE});
    end
    checks++;
    if ({MEMADD, MEMDAT_OUT, IF_DATA, DA_RDATA} !== 104'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {MEMADD, MEMDAT_OUT, IF_DATA, DA_RDATA});
    end
    Reset = 1;
    @(negedge Clk);
  endtask

  task automatic test_tie();
    bit got, err_at, mfa_at, pulse_ok, stable;
    int cyc;
    mem_en = 1; mem_delay = 3; MEMDAT_IN = 32'hCAFEF00D;
    IF_ADDR = 8'h11; DA_ADDR = 8'h22; DA_RW = 1; DA_WB = 1;
    IF_REQ = 1; DA_REQ = 1;
    @(negedge Clk);
    checks++;
    if ({MFA, MEMADD} !== {1'b1, 8'h22}) begin
      fails++;
      $display("FAIL tie_first_da: got mfa=%b addr=%h expected mfa=1 addr=22", MFA, MEMADD);
    end
    xfer_wait(1, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, mfa_at, err_at, pulse_ok} !== 4'b1001) begin
      fails++;
      $display("FAIL tie_da_ack: got ack/mfa/err/pulse=%b expected 1001", {got, mfa_at, err_at, pulse_ok});
    end
    checks++;
    if (DA_RDATA !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL tie_da_rdata: got %h expected cafef00d", DA_RDATA);
    end
    checks++;
    if (MFA !== 1'b0) begin
      fails++;
      $display("FAIL tie_mfa_gap: got %b expected 0", MFA);
    end
    DA_REQ = 1;
    @(negedge Clk);
    checks++;
    if ({MFA, MEMADD} !== {1'b1, 8'h11}) begin
      fails++;
      $display("FAIL tie_second_if: got mfa=%b addr=%h expected mfa=1 addr=11", MFA, MEMADD);
    end
    xfer_wait(0, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, pulse_ok, IF_DATA} !== {2'b11, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL tie_if_done: got ack=%b pulse=%b data=%h expected 1 1 cafef00d", got, pulse_ok, IF_DATA);
    end
    xfer_wait(1, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, pulse_ok} !== 2'b11) begin
      fails++;
      $display("FAIL tie_da_again: got ack=%b pulse=%b expected 1 1", got, pulse_ok);
    end
  endtask

  task automatic test_fetch();
    bit got, err_at, mfa_at, pulse_ok, stable;
    int cyc;
    mem_en = 1; mem_delay = 5; MEMDAT_IN = 32'hE5D13002;
    IF_ADDR = 8'h03; IF_REQ = 1;
    @(negedge Clk);
    checks++;
    if ({MFA, MEMADD, READ_WRITE, WORD_BYTE} !== {1'b1, 8'h03, 2'b11}) begin
      fails++;
      $display("FAIL fetch_issue: got mfa=%b addr=%h rw=%b wb=%b expected 1 03 1 1",
               MFA, MEMADD, READ_WRITE, WORD_BYTE);
    end
    xfer_wait(0, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, err_at, mfa_at, pulse_ok, stable} !== 5'b10011) begin
      fails++;
      $display("FAIL fetch_ack: got ack/err/mfa/pulse/stable=%b expected 10011",
               {got, err_at, mfa_at, pulse_ok, stable});
    end
    checks++;
    if (cyc != 11) begin
      fails++;
      $display("FAIL fetch_latency: got %0d expected 11", cyc);
    end
    checks++;
    if (IF_DATA !== 32'hE5D13002) begin
      fails++;
      $display("FAIL fetch_data: got %h expected e5d13002", IF_DATA);
    end
  endtask

  task automatic test_byte_write();
    bit got, err_at, mfa_at, pulse_ok, stable;
    int cyc;
    mem_en = 1; mem_delay = 4; MEMDAT_IN = 32'hFFFFFFFF;
    DA_RW = 0; DA_WB = 0; DA_ADDR = 8'h20; DA_WDATA = 32'h000000AB; DA_REQ = 1;
    @(negedge Clk);
    checks++;
    if ({MFA, MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT} !== {1'b1, 8'h20, 2'b00, 32'h000000AB}) begin
      fails++;
      $display("FAIL bw_issue: got mfa=%b addr=%h rw=%b wb=%b dout=%h expected 1 20 0 0 000000ab",
               MFA, MEMADD, READ_WRITE, WORD_BYTE, MEMDAT_OUT);
    end
    xfer_wait(1, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, err_at, pulse_ok, stable} !== 4'b1011) begin
      fails++;
      $display("FAIL bw_ack: got ack/err/pulse/stable=%b expected 1011", {got, err_at, pulse_ok, stable});
    end
    checks++;
    if (DA_RDATA !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL bw_rdata_kept: got %h expected cafef00d", DA_RDATA);
    end
  endtask

  task automatic test_byte_read();
    bit got, err_at, mfa_at, pulse_ok, stable;
    int cyc;
    mem_en = 1; mem_delay = 2; MEMDAT_IN = 32'h12345678;
    DA_RW = 1; DA_WB = 0; DA_ADDR = 8'h40; DA_REQ = 1;
    @(negedge Clk);
    xfer_wait(1, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, err_at, pulse_ok} !== 3'b101) begin
      fails++;
      $display("FAIL br_ack: got ack/err/pulse=%b expected 101", {got, err_at, pulse_ok});
    end
    checks++;
    if (DA_RDATA !== 32'h00000078) begin
      fails++;
      $display("FAIL br_data: got %h expected 00000078", DA_RDATA);
    end
    checks++;
    if (IF_DATA !== 32'hE5D13002) begin
      fails++;
      $display("FAIL br_if_kept: got %h expected e5d13002", IF_DATA);
    end
  endtask

  task automatic test_timeout();
    bit got, err_at, mfa_at, pulse_ok, stable;
    int cyc;
    mem_en = 0; MEMDAT_IN = 32'hDEADBEEF;
    DA_RW = 1; DA_WB = 1; DA_ADDR = 8'h55; DA_REQ = 1;
    @(negedge Clk);
    xfer_wait(1, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, err_at, mfa_at, pulse_ok} !== 4'b1101) begin
      fails++;
      $display("FAIL to_ack_err: got ack/err/mfa/pulse=%b expected 1101", {got, err_at, mfa_at, pulse_ok});
    end
    checks++;
    if (cyc != TO) begin
      fails++;
      $display("FAIL to_latency: got %0d expected %0d", cyc, TO);
    end
    checks++;
    if (DA_RDATA !== 32'h00000078) begin
      fails++;
      $display("FAIL to_rdata_kept: got %h expected 00000078", DA_RDATA);
    end
  endtask

  task automatic test_reset_mid();
    bit got, err_at, mfa_at, pulse_ok, stable;
    int cyc;
    int acks;
    mem_en = 0; IF_ADDR = 8'h07; IF_REQ = 1;
    @(negedge Clk);
    checks++;
    if (MFA !== 1'b1) begin
      fails++;
      $display("FAIL rm_started: got mfa=%b expected 1", MFA);
    end
    repeat (3) @(negedge Clk);
    #2 Reset = 0;
    #1;
    checks++;
    if ({MFA, MEMADD, IF_DATA} !== 41'h0) begin
      fails++;
      $display("FAIL rm_async: got mfa=%b addr=%h ifdata=%h expected 0 00 0", MFA, MEMADD, IF_DATA);
    end
    IF_REQ = 0;
    @(negedge Clk);
    Reset = 1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (IF_ACK || DA_ACK || ERR || MFA) acks++;
    end
    checks++;
    if (acks != 0) begin
      fails++;
      $display("FAIL rm_no_ack: got %0d active cycles expected 0", acks);
    end
    mem_en = 1; mem_delay = 2; MEMDAT_IN = 32'hA5A50F0F;
    IF_ADDR = 8'h09; IF_REQ = 1;
    @(negedge Clk);
    xfer_wait(0, 60, got, cyc, err_at, mfa_at, pulse_ok, stable);
    checks++;
    if ({got, err_at, pulse_ok, IF_DATA} !== {3'b101, 32'hA5A50F0F}) begin
      fails++;
      $display("FAIL rm_recover: got ack=%b err=%b pulse=%b data=%h expected 1 0 1 a5a50f0f",
               got, err_at, pulse_ok, IF_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_fetch();
    test_byte_write();
    test_byte_read();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
